// File: rtl/r4mdc_frame_ctrl.sv
// r4mdc_frame_ctrl: frame sequencer for the 16-point radix-4 MDC FFT datapath
module r4mdc_frame_ctrl #(
    parameter int WL         = 16,
    parameter int STAGE2_LEN = 16,
    parameter int OUT_DLY    = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            err_clr,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [2*WL-1:0] s_data,
    output logic [2*WL-1:0] dp_in,
    output logic            dp_en_comm1,
    output logic            dp_en_comm2,
    input  logic            dp_valid_but1,
    input  logic            dp_valid_but2,
    input  logic [WL-1:0]   dp_out_r,
    input  logic [WL-1:0]   dp_out_i,
    output logic            m_valid,
    output logic [2*WL-1:0] m_data,
    output logic [3:0]      m_index,
    output logic            m_last,
    output logic            busy,
    output logic            err_timeout,
    output logic [15:0]     frame_count
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WB1   = 3'd2;
    localparam logic [2:0] S_ST2   = 3'd3;
    localparam logic [2:0] S_WB2   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
    localparam int S2W = $clog2(STAGE2_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [S2W-1:0] S2_LAST   = S2W'(STAGE2_LEN - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
    localparam logic [4:0]     POS_FIRST = 5'(OUT_DLY);
    localparam logic [4:0]     POS_LAST  = 5'(OUT_DLY + 15);

    logic [2:0]      state_q, state_d;
    logic [3:0]      ld_q, ld_d;
    logic [S2W-1:0]  s2_q, s2_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [4:0]      pos_q, pos_d;
    logic            err_q, err_d;
    logic [15:0]     fc_q, fc_d;
    logic [2*WL-1:0] din_q, din_d, md_q, md_d;
    logic            en1_q, en1_d, en2_q, en2_d, mv_q, mv_d, ml_q, ml_d;
    logic [3:0]      mi_q, mi_d;
    logic            accept, capture, b2_first;

    assign s_ready     = ~rst & (state_q == S_IDLE || state_q == S_LOAD);
    assign accept      = s_valid & s_ready;
    // pos_q counts edges since the first second-butterfly valid; 0 means not yet seen
    assign capture     = pos_q >= POS_FIRST && pos_q <= POS_LAST;
    assign b2_first    = (state_q == S_ST2 || state_q == S_WB2) && dp_valid_but2 && pos_q == 5'd0;
    assign busy        = state_q != S_IDLE;
    assign dp_in       = din_q;
    assign dp_en_comm1 = en1_q;
    assign dp_en_comm2 = en2_q;
    assign m_valid     = mv_q;
    assign m_data      = md_q;
    assign m_index     = mi_q;
    assign m_last      = ml_q;
    assign err_timeout = err_q;
    assign frame_count = fc_q;

    // next-state: handshake capture, sequencing, watchdog, output re-timing; abort overrides all
    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        s2_d    = s2_q;
        wd_d    = wd_q;
        pos_d   = pos_q != 5'd0 ? pos_q + 5'd1 : (b2_first ? 5'd1 : 5'd0);
        err_d   = err_clr ? 1'b0 : err_q;
        fc_d    = fc_q;
        din_d   = accept ? s_data : din_q;
        en1_d   = accept;
        en2_d   = 1'b0;
        mv_d    = capture;
        md_d    = capture ? {dp_out_r, dp_out_i} : md_q;
        mi_d    = capture ? 4'(pos_q - POS_FIRST) : mi_q;
        ml_d    = capture && pos_q == POS_LAST;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                    ld_d    = 4'd1;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    ld_d = ld_q + 4'd1;
                    if (ld_q == 4'd15) begin
                        state_d = S_WB1;
                        wd_d    = '0;
                    end
                end
            end
            S_WB1: begin
                if (dp_valid_but1) begin
                    state_d = S_ST2;
                    en2_d   = 1'b1;
                    s2_d    = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_ST2: begin
                en2_d = s2_q != S2_LAST;
                s2_d  = s2_q + S2W'(1);
                if (s2_q == S2_LAST) begin
                    state_d = (pos_q != 5'd0 || dp_valid_but2) ? S_DRAIN : S_WB2;
                    wd_d    = '0;
                end
            end
            S_WB2: begin
                if (dp_valid_but2) begin
                    state_d = S_DRAIN;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_DRAIN: begin
                if (ml_q) begin
                    state_d = S_IDLE;
                    fc_d    = fc_q + 16'd1;
                    pos_d   = 5'd0;
                end
            end
            S_ERR: begin
                if (err_clr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            ld_d    = '0;
            s2_d    = '0;
            wd_d    = '0;
            pos_d   = '0;
            err_d   = err_q & ~err_clr;
            fc_d    = fc_q;
            din_d   = din_q;
            en1_d   = 1'b0;
            en2_d   = 1'b0;
            mv_d    = 1'b0;
            md_d    = md_q;
            mi_d    = mi_q;
            ml_d    = 1'b0;
        end
    end

    // state and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ld_q    <= '0;
            s2_q    <= '0;
            wd_q    <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
            fc_q    <= '0;
            din_q   <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            mv_q    <= 1'b0;
            md_q    <= '0;
            mi_q    <= '0;
            ml_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            s2_q    <= s2_d;
            wd_q    <= wd_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            fc_q    <= fc_d;
            din_q   <= din_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            mi_q    <= mi_d;
            ml_q    <= ml_d;
        end
    end
endmodule

// File: doc/r4mdc_frame_ctrl.md
# r4mdc_frame_ctrl

Frame-level sequencer for the 16-point radix-4 MDC FFT datapath. It accepts complex input samples over a valid/ready handshake and drives the datapath's two commutator enables. It tracks both butterfly-stage valid flags and re-times the serial FFT result into a framed output stream with index and last markers. One frame is in flight at a time; a watchdog flags a datapath that stops responding.

## Interface
- WL, 16, real/imag word length.
- STAGE2_LEN, 16, cycles `dp_en_comm2` is held high per frame.
- OUT_DLY, 1, cycles from the first sampled-high `dp_valid_but2` to the first `m_valid`; range 1..3.
- TIMEOUT, 64, maximum cycles spent in WAIT_B1 or WAIT_B2 before error.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous; returns the block to IDLE.
- err_clr  in  1  synchronous; clears `err_timeout`.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_data  in  2*WL  input sample, {real, imag}.
- dp_in  out  2*WL  sample to the datapath `in` port.
- dp_en_comm1  out  1  input-commutator enable.
- dp_en_comm2  out  1  output-commutator stage enable.
- dp_valid_but1  in  1  first-butterfly output valid.
- dp_valid_but2  in  1  second-butterfly output valid.
- dp_out_r, dp_out_i  in  WL each  datapath result.
- m_valid  out  1  output sample valid; no backpressure.
- m_data  out  2*WL  {real, imag} result.
- m_index  out  4  bin index, 0..15.
- m_last  out  1  high with index 15.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky watchdog flag.
- frame_count  out  16  completed frames; wraps at 65535→0.

## Operation
- States: IDLE, LOAD, WAIT_B1, STAGE2, WAIT_B2, DRAIN, ERROR.
- `s_ready` is a combinational decode: high only in IDLE or LOAD (and never during reset).
- Accept: a handshake is a cycle with `s_valid & s_ready`.
  - Each accept registers `dp_in <= s_data` and `dp_en_comm1 <= 1`.
  - Cycles without an accept drive `dp_en_comm1 <= 0` and hold `dp_in`. Bubbles are legal: the datapath only advances on enable.
- IDLE → LOAD on the first accept; the load counter is set to 1.
- LOAD: the counter increments per accept. The 16th accept moves to WAIT_B1, so `s_ready` drops the following cycle.
- WAIT_B1 → STAGE2 when `dp_valid_but1` is sampled high.
  - `dp_en_comm2` goes high the next cycle and stays high exactly STAGE2_LEN cycles.
  - STAGE2 → WAIT_B2 after the last of those cycles.
- `dp_valid_but2` is also monitored from STAGE2 onward. The first sampled-high cycle (T) arms the output alignment counter, and the state moves to DRAIN (from WAIT_B2, or directly after STAGE2 completes if T fell inside STAGE2).
- DRAIN:
  - From cycle T+OUT_DLY+1, register `m_data <= {dp_out_r, dp_out_i}` and `m_valid <= 1` for 16 consecutive cycles, with `m_index` counting 0..15.
  - `m_last` is high on index 15 only.
  - After index 15: `frame_count += 1` and return to IDLE.
- Watchdog: a cycle counter resets on entry to WAIT_B1 and WAIT_B2. Reaching TIMEOUT while still waiting → ERROR and sets `err_timeout`.
- ERROR: all enables are 0 and `s_ready` is 0. The state returns to IDLE on `err_clr` or `abort`. `err_timeout` clears only on `err_clr` or `rst`.
- `abort`, in any state, takes effect the next cycle:
  - state is IDLE;
  - `dp_en_comm1`, `dp_en_comm2`, `m_valid`, `m_last` are 0 and all counters are 0;
  - `frame_count` is unchanged.
- Simultaneous events: `abort` has priority over everything. `err_clr` together with a timeout in the same cycle leaves `err_timeout` set.
- Reset values: `dp_in`, `m_data`, `m_index`, `frame_count` = 0. `dp_en_comm1`, `dp_en_comm2`, `m_valid`, `m_last`, `busy`, `err_timeout` = 0. State is IDLE.

## Timing
- Accept at edge k → `dp_en_comm1`/`dp_in` are valid during cycle k+1.
- `dp_valid_but1` sampled at edge t → `dp_en_comm2` is high over cycles t+1 .. t+STAGE2_LEN.
- `dp_valid_but2` sampled at edge T → `m_valid` is high over cycles T+OUT_DLY+1 .. T+OUT_DLY+16.
- Best-case turnaround from the last output to the next accept is 1 cycle: the DRAIN→IDLE edge raises `s_ready`.
- `m_data` passes through unchanged; the block does no arithmetic on it.

## Test plan
- Reset then 16 back-to-back samples 0x0001_0000..0x0010_0000 → `dp_en_comm1` high exactly 16 cycles; `s_ready` low from the cycle after the 16th accept.
- `s_valid` toggling 1/0 → `dp_en_comm1` pulses 16 times over 32 cycles, and `dp_in` holds its value on bubble cycles.
- Model `dp_valid_but1` 5 cycles after the last load and `dp_valid_but2` at T → `dp_en_comm2` high 16 cycles; `m_valid` over T+2..T+17 with `m_index` 0..15, `m_last` at 15, `frame_count` = 1.
- `dp_valid_but1` never asserted → `err_timeout` = 1 after 64 WAIT_B1 cycles, `s_ready` = 0; `err_clr` → IDLE, flag = 0.
- `abort` mid-DRAIN at index 7 → next cycle `m_valid` = 0, `busy` = 0, `frame_count` unchanged.
- Async `rst` pulsed between clock edges mid-STAGE2 → all outputs immediately at reset values; `dp_en_comm2` = 0 before the next edge.
